// File: rtl/parallel_key_search_ctrl.sv
// Parallel key-search controller: hands consecutive keys to a pool of decryption
// cores and stops the whole pool on the first core that reports a valid message.
module parallel_key_search_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter int KEY_BITS  = 22
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic [KEY_BITS-1:0]            key_lo,
  input  logic [KEY_BITS-1:0]            key_hi,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           core_abort,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_valid,
  output logic                           busy,
  output logic                           found,
  output logic                           not_found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [2:0]                     found_core,
  output logic [KEY_BITS:0]              keys_tried
);

  // state       | meaning
  // S_IDLE      | waiting for the first start after reset
  // S_RUN       | dispatching keys to idle cores
  // S_DRAIN     | every key dispatched, waiting for busy cores to finish
  // S_FOUND     | valid key latched, cores aborted
  // S_NOT_FOUND | range exhausted with no valid key
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_FOUND     = 3'd3;
  localparam logic [2:0] S_NOT_FOUND = 3'd4;

  logic [2:0]                     state_q, state_d;
  logic [KEY_BITS:0]              next_key_q, next_key_d;
  logic [KEY_BITS-1:0]            end_key_q, end_key_d;
  logic [NUM_CORES-1:0]           core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]           core_start_d;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_d;
  logic                           core_abort_d;
  logic [KEY_BITS:0]              keys_tried_d;
  logic [KEY_WIDTH-1:0]           found_key_d;
  logic [2:0]                     found_core_d;

  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] idle_sel;
  logic [3:0]           done_cnt;
  logic [2:0]           hit_idx;
  logic [KEY_WIDTH-1:0] hit_key;
  logic [KEY_WIDTH-1:0] dispatch_key;
  logic                 last_key;

  assign hit          = core_done & core_valid;
  assign dispatch_key = KEY_WIDTH'(next_key_q[KEY_BITS-1:0]);
  assign last_key     = (next_key_q[KEY_BITS-1:0] == end_key_q);

  // Walking from the top down leaves the lowest-index idle core and valid hit selected.
  always_comb begin
    idle_sel = '0;
    hit_idx  = '0;
    hit_key  = '0;
    done_cnt = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_busy_q[i]) begin
        idle_sel    = '0;
        idle_sel[i] = 1'b1;
      end
      if (hit[i]) begin
        hit_idx = 3'(i);
        hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
      done_cnt = done_cnt + 4'(core_done[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    end_key_d    = end_key_q;
    core_busy_d  = core_busy_q;
    core_start_d = '0;
    core_key_d   = core_key;
    core_abort_d = 1'b0;
    keys_tried_d = keys_tried;
    found_key_d  = found_key;
    found_core_d = found_core;

    case (state_q)
      S_IDLE, S_FOUND, S_NOT_FOUND: begin
        if (start) begin
          next_key_d   = {1'b0, key_lo};
          end_key_d    = key_hi;
          keys_tried_d = '0;
          found_key_d  = '0;
          found_core_d = '0;
          core_busy_d  = '0;
          state_d      = (key_lo > key_hi) ? S_NOT_FOUND : S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        keys_tried_d = keys_tried + (KEY_BITS+1)'(done_cnt);
        // A core finishing this cycle is still seen as busy by idle_sel, so it waits a cycle.
        core_busy_d  = core_busy_q & ~core_done;
        if (|hit) begin
          state_d      = S_FOUND;
          found_key_d  = hit_key;
          found_core_d = hit_idx;
          core_abort_d = 1'b1;
          core_busy_d  = '0;
        end else if (state_q == S_RUN) begin
          if (|idle_sel) begin
            core_start_d = idle_sel;
            core_busy_d  = core_busy_d | idle_sel;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (idle_sel[i]) core_key_d[i*KEY_WIDTH +: KEY_WIDTH] = dispatch_key;
            end
            next_key_d = next_key_q + (KEY_BITS+1)'(1);
            if (last_key) state_d = S_DRAIN;
          end
        end else if (core_busy_d == '0) begin
          state_d = S_NOT_FOUND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      next_key_q  <= '0;
      end_key_q   <= '0;
      core_busy_q <= '0;
      core_start  <= '0;
      core_key    <= '0;
      core_abort  <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      not_found   <= 1'b0;
      found_key   <= '0;
      found_core  <= '0;
      keys_tried  <= '0;
    end else begin
      state_q     <= state_d;
      next_key_q  <= next_key_d;
      end_key_q   <= end_key_d;
      core_busy_q <= core_busy_d;
      core_start  <= core_start_d;
      core_key    <= core_key_d;
      core_abort  <= core_abort_d;
      busy        <= (state_d == S_RUN) || (state_d == S_DRAIN);
      found       <= (state_d == S_FOUND);
      not_found   <= (state_d == S_NOT_FOUND);
      found_key   <= found_key_d;
      found_core  <= found_core_d;
      keys_tried  <= keys_tried_d;
    end
  end

endmodule

// File: tb/tb_parallel_key_search_ctrl.sv
// Bench for parallel_key_search_ctrl: behavioural core pool plus outcome rules
// (first valid key wins, otherwise every key in range is tried exactly once).
module tb_parallel_key_search_ctrl;
  localparam int NC = 4;
  localparam int KW = 24;
  localparam int KB = 22;

  logic             CLOCK_50 = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [KB-1:0]    key_lo = '0;
  logic [KB-1:0]    key_hi = '0;
  logic [NC-1:0]    core_start;
  logic [NC*KW-1:0] core_key;
  logic             core_abort;
  logic [NC-1:0]    core_done = '0;
  logic [NC-1:0]    core_valid = '0;
  logic             busy, found, not_found;
  logic [KW-1:0]    found_key;
  logic [2:0]       found_core;
  logic [KB:0]      keys_tried;

  logic       s_start = 1'b0;
  logic [3:0] s_key_lo = '0;
  logic [3:0] s_key_hi = '0;
  logic [0:0] s_core_start;
  logic [7:0] s_core_key;
  logic       s_core_abort;
  logic [0:0] s_core_done = '0;
  logic [0:0] s_core_valid = '0;
  logic       s_busy, s_found, s_not_found;
  logic [7:0] s_found_key;
  logic [2:0] s_found_core;
  logic [4:0] s_keys_tried;

  parallel_key_search_ctrl #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_BITS(KB)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .key_lo(key_lo), .key_hi(key_hi),
    .core_start(core_start), .core_key(core_key), .core_abort(core_abort),
    .core_done(core_done), .core_valid(core_valid), .busy(busy), .found(found),
    .not_found(not_found), .found_key(found_key), .found_core(found_core),
    .keys_tried(keys_tried)
  );

  parallel_key_search_ctrl #(.NUM_CORES(1), .KEY_WIDTH(8), .KEY_BITS(4)) dut_small (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(s_start), .key_lo(s_key_lo), .key_hi(s_key_hi),
    .core_start(s_core_start), .core_key(s_core_key), .core_abort(s_core_abort),
    .core_done(s_core_done), .core_valid(s_core_valid), .busy(s_busy), .found(s_found),
    .not_found(s_not_found), .found_key(s_found_key), .found_core(s_found_core),
    .keys_tried(s_keys_tried)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    string name;
    int    lo;
    int    hi;
    int    target;     // -1: no valid key
    int    exp_found;
    int    exp_key;
    int    exp_core;   // -1: core that the pool model handed the key to
    int    exp_tried;  // -1: result count from the pool model
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  bit pend[NC];
  int cnt[NC];
  int ckey[NC];
  int lat_cfg[NC];
  bit rand_lat, rand_start;
  int vkeys[$];
  int exp_next, cur_hi, dones, aborts, first_key, post_starts, cyc, t_cyc;
  bit m_found;
  int m_core, m_key;
  bit term, g_found, g_nf, g_busy;
  int g_key, g_core, g_tried;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_valid(input int k);
    foreach (vkeys[j]) if (vkeys[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pool_clear();
    for (int i = 0; i < NC; i++) pend[i] = 1'b0;
    core_done  = '0;
    core_valid = '0;
  endtask

  // One clock of the core-pool model; everything sampled 1 time unit after the edge.
  task automatic tb_cycle();
    bit pb[NC];
    int k;
    @(posedge CLOCK_50);
    #1;
    cyc++;
    start = 1'b0;
    if (core_abort) begin
      aborts++;
      for (int i = 0; i < NC; i++) pend[i] = 1'b0;
    end
    for (int i = 0; i < NC; i++) pb[i] = pend[i];
    core_done  = '0;
    core_valid = '0;
    for (int i = 0; i < NC; i++) begin
      if (pend[i]) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          core_done[i]  = 1'b1;
          core_valid[i] = is_valid(ckey[i]);
          pend[i] = 1'b0;
          dones++;
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (!m_found && core_done[i] && core_valid[i]) begin
        m_found = 1'b1;
        m_core  = i;
        m_key   = ckey[i];
      end
    end
    if (core_start != '0) begin
      chk("one_start_per_cycle", longint'($countones(core_start)), 1);
      if (term) post_starts++;
    end
    for (int i = 0; i < NC; i++) begin
      if (core_start[i]) begin
        k = int'(core_key[i*KW +: KW]);
        chk("start_to_idle_core", longint'(pb[i]), 0);
        chk("dispatch_key", k, exp_next);
        chk("dispatch_in_range", longint'(k <= cur_hi), 1);
        if (first_key < 0) first_key = k;
        exp_next++;
        pend[i] = 1'b1;
        cnt[i]  = rand_lat ? int'($urandom_range(1, 8)) : lat_cfg[i];
        ckey[i] = k;
      end
    end
    if (!term && (found || not_found)) begin
      term    = 1'b1;
      t_cyc   = cyc;
      g_found = found;
      g_nf    = not_found;
      g_busy  = busy;
      g_key   = int'(found_key);
      g_core  = int'(found_core);
      g_tried = int'(keys_tried);
    end
    if (rand_start && busy && !term && $urandom_range(0, 7) == 0) begin
      start  = 1'b1;
      key_lo = KB'($urandom_range(0, 200));
      key_hi = KB'($urandom_range(0, 200));
    end
  endtask

  task automatic run_search(input int lo, input int hi);
    pool_clear();
    exp_next = lo; cur_hi = hi; dones = 0; aborts = 0; first_key = -1;
    post_starts = 0; m_found = 1'b0; m_core = -1; m_key = -1; term = 1'b0; cyc = 0;
    key_lo = KB'(lo);
    key_hi = KB'(hi);
    start  = 1'b1;
    while (!term && cyc < 3000) tb_cycle();
    if (!term) begin
      n_checks++;
      n_errors++;
      $display("FAIL search_timeout: no found/not_found after %0d cycles, range %0d..%0d", cyc, lo, hi);
    end
    repeat (4) tb_cycle();
    chk("abort_pulses", aborts, g_found ? 1 : 0);
    chk("no_start_after_end", post_starts, 0);
    chk("busy_at_end", longint'(g_busy), 0);
    chk("flags_exclusive", longint'(g_found) + longint'(g_nf), 1);
    chk("result_held", longint'(keys_tried), g_tried);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_found"}, longint'(found), 0);
    chk({tag, "_not_found"}, longint'(not_found), 0);
    chk({tag, "_core_start"}, longint'(core_start), 0);
    chk({tag, "_core_abort"}, longint'(core_abort), 0);
    chk({tag, "_core_key"}, longint'(core_key), 0);
    chk({tag, "_found_key"}, longint'(found_key), 0);
    chk({tag, "_found_core"}, longint'(found_core), 0);
    chk({tag, "_keys_tried"}, longint'(keys_tried), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lo, hi, tgt, in_rng, s_next, s_cnt, s_post, s_term_c;
    bit s_pend, s_term;

    // Fixed 5-cycle cores hand out keys round-robin, so key k lands on core (k-lo)%4.
    vecs[0] = '{"range0_9",    0,   9,  -1, 0,  0, -1, 10};
    vecs[1] = '{"key37",       0, 100,  37, 1, 37,  1, -1};
    vecs[2] = '{"lo_gt_hi",    5,   4,  -1, 0,  0, -1,  0};
    vecs[3] = '{"single_hit", 20,  20,  20, 1, 20,  0,  1};
    vecs[4] = '{"single_miss", 7,   7,  -1, 0,  0, -1,  1};
    vecs[5] = '{"last_key",    3,  12,  12, 1, 12,  1, -1};
    vecs[6] = '{"below_range",50,  60,  49, 0,  0, -1, 11};
    vecs[7] = '{"first_key",  30,  40,  30, 1, 30,  0,  1};

    repeat (2) @(posedge CLOCK_50);
    #1;
    check_zero("reset");
    chk("small_reset_tried", longint'(s_keys_tried), 0);
    reset = 1'b0;

    rand_lat = 1'b0;
    rand_start = 1'b0;
    lat_cfg = '{5, 5, 5, 5};
    foreach (vecs[v]) begin
      vkeys.delete();
      if (vecs[v].target >= 0) vkeys.push_back(vecs[v].target);
      run_search(vecs[v].lo, vecs[v].hi);
      chk({vecs[v].name, "_found"}, longint'(g_found), vecs[v].exp_found);
      chk({vecs[v].name, "_not_found"}, longint'(g_nf), 1 - vecs[v].exp_found);
      chk({vecs[v].name, "_tried"}, g_tried, (vecs[v].exp_tried >= 0) ? vecs[v].exp_tried : dones);
      if (vecs[v].exp_found != 0) begin
        chk({vecs[v].name, "_key"}, g_key, vecs[v].exp_key);
        chk({vecs[v].name, "_core"}, g_core, (vecs[v].exp_core >= 0) ? vecs[v].exp_core : m_core);
        chk({vecs[v].name, "_core_holds_key"}, g_core, m_core);
      end else begin
        chk({vecs[v].name, "_all_dispatched"}, exp_next, (vecs[v].lo > vecs[v].hi) ? vecs[v].lo : vecs[v].hi + 1);
      end
      if (vecs[v].lo > vecs[v].hi) begin
        chk({vecs[v].name, "_nf_latency"}, t_cyc, 1);
        chk({vecs[v].name, "_no_dispatch"}, first_key, -1);
      end
    end

    // Cores 1 and 3 report valid in the same cycle; the lower index wins.
    lat_cfg = '{20, 6, 20, 4};
    vkeys.delete();
    vkeys.push_back(1);
    vkeys.push_back(3);
    run_search(0, 100);
    chk("tie_found", longint'(g_found), 1);
    chk("tie_core", g_core, 1);
    chk("tie_key", g_key, 1);
    chk("tie_tried", g_tried, 2);

    // Reset mid-search, then a fresh 0..3 search.
    lat_cfg = '{5, 5, 5, 5};
    vkeys.delete();
    pool_clear();
    exp_next = 0; cur_hi = 100; first_key = -1; aborts = 0; term = 1'b0;
    m_found = 1'b0; post_starts = 0;
    key_lo = '0;
    key_hi = KB'(100);
    start  = 1'b1;
    repeat (8) tb_cycle();
    chk("rst_busy_before", longint'(busy), 1);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    pool_clear();
    check_zero("midrun_reset");
    aborts = 0;
    term = 1'b1;
    repeat (3) tb_cycle();
    chk("rst_no_abort", aborts, 0);
    chk("rst_idle_no_start", post_starts, 0);
    run_search(0, 3);
    chk("rst_first_key", first_key, 0);
    chk("rst_not_found", longint'(g_nf), 1);
    chk("rst_tried", g_tried, 4);

    // Randomised ranges, latencies, targets and ignored start pulses.
    rand_lat = 1'b1;
    rand_start = 1'b1;
    for (int r = 0; r < 30; r++) begin
      lo = int'($urandom_range(1, 60));
      hi = ($urandom_range(0, 7) == 0) ? lo - 1 : lo + int'($urandom_range(0, 40));
      vkeys.delete();
      tgt = -1;
      if ($urandom_range(0, 3) != 0) begin
        tgt = int'($urandom_range(lo - 1, hi + 3));
        vkeys.push_back(tgt);
      end
      in_rng = (tgt >= lo && tgt <= hi) ? 1 : 0;
      run_search(lo, hi);
      chk("rnd_found", longint'(g_found), in_rng);
      if (in_rng != 0) begin
        chk("rnd_key", g_key, tgt);
        chk("rnd_core", g_core, m_core);
        chk("rnd_tried", g_tried, dones);
      end else begin
        chk("rnd_tried", g_tried, (hi >= lo) ? hi - lo + 1 : 0);
        chk("rnd_all_dispatched", exp_next, (hi >= lo) ? hi + 1 : lo);
      end
    end
    rand_start = 1'b0;

    // Single-core instance over the full 4-bit key space: no wrap after key 15.
    s_key_lo = 4'd0;
    s_key_hi = 4'd15;
    s_start  = 1'b1;
    s_next = 0; s_cnt = 0; s_post = 0; s_term_c = 0;
    s_pend = 1'b0; s_term = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge CLOCK_50);
      #1;
      s_start = 1'b0;
      s_core_done = 1'b0;
      if (s_pend) begin
        s_cnt--;
        if (s_cnt == 0) begin
          s_core_done = 1'b1;
          s_pend = 1'b0;
        end
      end
      if (s_core_start[0]) begin
        if (s_term) s_post++;
        else begin
          chk("small_key", longint'(s_core_key), s_next);
          s_next++;
        end
        s_pend = 1'b1;
        s_cnt  = 2;
      end
      if (!s_term && (s_not_found || s_found)) begin
        s_term   = 1'b1;
        s_term_c = c;
      end
      if (s_term && c >= s_term_c + 5) break;
    end
    if (!s_term) begin
      n_checks++;
      n_errors++;
      $display("FAIL small_timeout: single-core search never finished");
    end
    chk("small_not_found", longint'(s_not_found), 1);
    chk("small_tried", longint'(s_keys_tried), 16);
    chk("small_dispatched", s_next, 16);
    chk("small_no_wrap", s_post, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parallel_key_search_ctrl.md
PARALLEL_KEY_SEARCH_CTRL -- requirements
Module: parallel_key_search_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of decryption cores served (legal 1..8).
REQ-002 SHALL have parameter KEY_WIDTH, default 24: width of the key sent to each core.
REQ-003 SHALL have parameter KEY_BITS, default 22: width of the key counter (KEY_BITS <= KEY_WIDTH).
REQ-004 Ports:
- CLOCK_50 input 1: the single clock.
- reset input 1: synchronous, active-high.
- start input 1: begin a search over [key_lo, key_hi].
- key_lo input KEY_BITS: first key of the range.
- key_hi input KEY_BITS: last key of the range, inclusive.
- core_start output NUM_CORES: one-cycle launch pulse per core.
- core_key output NUM_CORES*KEY_WIDTH: key for core i, in slice i.
- core_abort output 1: one-cycle broadcast stop to all cores.
- core_done input NUM_CORES: one-cycle finish pulse per core.
- core_valid input NUM_CORES: message-valid verdict, qualified by core_done[i].
- busy output 1: search in progress.
- found output 1: a valid key has been located.
- not_found output 1: range exhausted with no valid key.
- found_key output KEY_WIDTH: the valid key.
- found_core output 3: index of the core that reported the valid key.
- keys_tried output KEY_BITS+1: count of completed core results.

Function
REQ-005 SHALL implement states IDLE, RUN, DRAIN, FOUND and NOT_FOUND.
REQ-006 IDLE->RUN on start=1; start SHALL be ignored in RUN and DRAIN, and SHALL restart the search from FOUND or NOT_FOUND.
REQ-007 On start, SHALL load next_key=key_lo and end_key=key_hi, and SHALL clear keys_tried, found, not_found, found_key, found_core and all per-core busy flags.
REQ-008 If key_lo > key_hi at start, SHALL go directly to NOT_FOUND on the next cycle, with no dispatch.
REQ-009 Per-core busy flag rules:
- set when core_start[i] is issued;
- cleared when core_done[i] is seen;
- a core cleared by core_done SHALL NOT be re-dispatched in that same cycle.
REQ-010 Dispatch in RUN:
- at most one core_start per cycle, to the lowest-index idle core;
- core_key slice SHALL equal next_key zero-extended to KEY_WIDTH, held stable from the core_start cycle until that core's next core_start;
- next_key SHALL increment after each dispatch.
REQ-011 After dispatching end_key, SHALL go RUN->DRAIN; DRAIN issues no further core_start.
REQ-012 Every core_done[i] SHALL increment keys_tried by 1; simultaneous done pulses SHALL add their popcount in one cycle.
REQ-013 A core_done[i] with core_valid[i]=1 in RUN or DRAIN SHALL:
- enter FOUND;
- latch found_key = key of core i and found_core = i;
- when several such cores report in the same cycle, take the lowest index.
REQ-014 On entering FOUND, SHALL pulse core_abort for exactly 1 cycle and clear all busy flags.
REQ-015 In FOUND, SHALL ignore core_done and core_valid, and SHALL hold found_key and found_core.
REQ-016 DRAIN->NOT_FOUND when no core is busy and no valid result arrives that cycle.
REQ-017 A valid result that arrives in the same cycle as the last busy flag clears SHALL take priority, so the state goes to FOUND.
REQ-018 next_key SHALL NOT wrap: with end_key = 2^KEY_BITS-1, dispatch stops after that key and keys_tried SHALL reach 2^KEY_BITS without overflow.
REQ-019 Output levels:
- busy=1 exactly in RUN and DRAIN;
- found=1 exactly in FOUND;
- not_found=1 exactly in NOT_FOUND;
- all outputs SHALL be registered.

Reset
REQ-020 reset=1 SHALL put the block in IDLE and take priority over start.
REQ-021 On reset, SHALL drive every output to 0 and clear all busy flags, next_key and end_key.
REQ-022 reset asserted mid-search SHALL NOT produce a core_abort pulse.

Verification
REQ-023 NUM_CORES=4, range 0..9, all core_valid=0, each core responds 5 cycles after its start -> core_start goes to cores 0,1,2,3 on consecutive cycles, keys 0..9 each dispatched exactly once, then not_found=1 with keys_tried=10.
REQ-024 Range 0..100, model returns core_valid=1 for key 37 only -> found=1, found_key=37, found_core = index of the core given key 37, one core_abort pulse, no core_start after the FOUND cycle.
REQ-025 Cores 1 and 3 both report done with valid=1 in the same cycle -> found_core=1 and found_key = core 1's key.
REQ-026 key_lo=5, key_hi=4 -> NOT_FOUND one cycle after start, no core_start.
REQ-027 Assert reset for one cycle during RUN, then start with range 0..3 -> all outputs 0 after the reset cycle, core_abort stays 0, and the new search dispatches key 0 first.
REQ-028 KEY_BITS=4, range 0..15, NUM_CORES=1 -> dispatch stops after key 15, keys_tried=16, next_key does not wrap to 0.
